// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: two-requester SPI master, mode-0 style frames, MSB first.
// Define SPI_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0 wins).
module spi_master_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [FRAME_BITS-1:0] tx_data0,
    input  logic [FRAME_BITS-1:0] tx_data1,
    output logic [1:0]            gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  SCLK,
    output logic                  SS,
    output logic                  MOSI,
    input  logic                  MISO
);
    localparam int BW = $clog2(FRAME_BITS + 1);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    logic ph;
    logic [BW-1:0] bit_cnt;
    logic [FRAME_BITS-1:0] tx_sh, rx_sh;
    logic cnt_end, start, sel;
`ifdef SPI_ARB_RR_EN
    logic ptr;
    assign sel = (&req) ? ptr : req[1];
`else
    assign sel = !req[0];
`endif
    assign cnt_end = cnt == 8'(CLK_DIV - 1);
    // the done cycle sits in IDLE but must not grant
    assign start = state == IDLE && !done && req != 2'b00 && !rst;
    assign gnt = start ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign busy = start || state != IDLE || done;
    assign SS = state != IDLE;
    assign SCLK = state == SHIFT && !ph;
    assign MOSI = SS && tx_sh[FRAME_BITS-1];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = start ? SETUP : IDLE;
            SETUP: state_nx = cnt_end ? SHIFT : SETUP;
            SHIFT: state_nx = (cnt_end && ph && bit_cnt == BW'(FRAME_BITS - 1)) ? HOLD : SHIFT;
            HOLD:  state_nx = cnt_end ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ph      <= 1'b0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            done    <= 1'b0;
            done_id <= 1'b0;
`ifdef SPI_ARB_RR_EN
            ptr     <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            done  <= state == HOLD && cnt_end;
            cnt   <= (state == IDLE || cnt_end) ? '0 : cnt + 8'd1;
            if (start) begin
                tx_sh   <= sel ? tx_data1 : tx_data0;
                done_id <= sel;
                ph      <= 1'b0;
                bit_cnt <= '0;
`ifdef SPI_ARB_RR_EN
                ptr     <= !sel;
`endif
            end
            // ph=0 is the high half; its end is the SCLK falling edge
            if (state == SHIFT && cnt_end) begin
                ph <= !ph;
                if (!ph) begin
                    tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
                    rx_sh <= {rx_sh[FRAME_BITS-2:0], MISO};
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
            if (state == HOLD && cnt_end) rx_data <= rx_sh;
        end
    end
endmodule
